// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with a signed/unsigned mode.
// It terminates early once no 1 bits remain in the multiplier magnitude.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      request, accepted only while busy=0
//   is_signed  1: a and b are two's complement; 0: unsigned (sampled with start)
//   a          multiplier operand, WIDTH bits (sampled with start)
//   b          multiplicand operand, WIDTH bits (sampled with start)
//   busy       high while an operation is in flight (RUN or FINISH)
//   done       one-cycle pulse when p holds a new result
//   p          2*WIDTH-bit product, held until the next done
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  mlt;
   logic [PW-1:0]     mcd;
   logic [PW-1:0]     acc;
   logic              neg;
   logic [WIDTH-1:0]  a_mag, b_mag;

   // Operand magnitudes. Truncating the negation to WIDTH bits is exact,
   // because the most negative value maps to 2^(WIDTH-1), which still fits
   // unsigned in WIDTH bits.
   always_comb begin
      a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and the busy flag.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (mlt == '0) state_nx = FINISH;
         end
         FINISH: begin
            busy     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mlt  <= '0;
         mcd  <= '0;
         acc  <= '0;
         neg  <= 1'b0;
         p    <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // A zero multiplicand empties mlt so RUN exits at once.
                  mlt <= (b == '0) ? '0 : a_mag;
                  mcd <= {{WIDTH{1'b0}}, b_mag};
                  acc <= '0;
                  neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            RUN: begin
               if (mlt != '0) begin
                  if (mlt[0]) acc <= acc + mcd;
                  mlt <= mlt >> 1;
                  mcd <= mcd << 1;
               end
            end
            FINISH: begin
               // Negating a zero accumulator gives zero again, so no -0 result.
               p    <= neg ? (~acc + 1'b1) : acc;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

   logic clk;
   logic rst;
   logic        start_v[4];
   logic        sgn_v[4];
   logic [63:0] a_v[4];
   logic [63:0] b_v[4];
   logic        busy_v[4];
   logic        done_v[4];
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;
   logic [63:0] p32;

   int cmp  = 0;
   int errs = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0..3 selects the DUT with WIDTH 4, 8, 16, 32.
   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .is_signed(sgn_v[0]),
      .a(a_v[0][3:0]), .b(b_v[0][3:0]), .busy(busy_v[0]), .done(done_v[0]), .p(p4));
   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start_v[1]), .is_signed(sgn_v[1]),
      .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]), .p(p8));
   seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start_v[2]), .is_signed(sgn_v[2]),
      .a(a_v[2][15:0]), .b(b_v[2][15:0]), .busy(busy_v[2]), .done(done_v[2]), .p(p16));
   seq_multiplier #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start_v[3]), .is_signed(sgn_v[3]),
      .a(a_v[3][31:0]), .b(b_v[3][31:0]), .busy(busy_v[3]), .done(done_v[3]), .p(p32));

   function automatic int wof(int d);
      case (d)
         0: return 4;
         1: return 8;
         2: return 16;
         default: return 32;
      endcase
   endfunction

   function automatic logic [127:0] get_p(int d);
      case (d)
         0: return {120'b0, p4};
         1: return {112'b0, p8};
         2: return {96'b0, p16};
         default: return {64'b0, p32};
      endcase
   endfunction

   // Operand as a mathematical integer.
   function automatic logic signed [127:0] to_int(int w, logic sg, logic [63:0] v);
      logic [63:0] m;
      logic signed [127:0] x;
      m = (64'd1 << w) - 64'd1;
      x = {64'b0, v & m};
      if (sg && v[w-1]) x = x - (128'sd1 <<< w);
      return x;
   endfunction

   function automatic logic [127:0] ref_mul(int w, logic sg, logic [63:0] av, logic [63:0] bv);
      logic signed [127:0] pr;
      pr = to_int(w, sg, av) * to_int(w, sg, bv);
      return pr & ((128'd1 << (2 * w)) - 128'd1);
   endfunction

   // Expected start-to-done distance: significant bits of |a| plus two.
   function automatic int ref_lat(int w, logic sg, logic [63:0] av, logic [63:0] bv);
      logic signed [127:0] x;
      int k;
      x = to_int(w, sg, av);
      if (x < 0) x = -x;
      if (to_int(w, sg, bv) == 0) return 2;
      k = 0;
      while (x != 0) begin
         x = x >>> 1;
         k++;
      end
      return k + 2;
   endfunction

   // Issue one operation and observe it. Called and returns at posedge+1.
   task automatic run_op(input int d, input logic sg, input logic [63:0] av,
                         input logic [63:0] bv, output logic [127:0] pv,
                         output int lat, output int bcnt, output bit clash);
      sgn_v[d] = sg; a_v[d] = av; b_v[d] = bv; start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      lat = -1; bcnt = 0; clash = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy_v[d]) bcnt++;
         if (busy_v[d] && done_v[d]) clash = 1'b1;
         if (done_v[d]) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      pv = get_p(d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         start_v[d] = 1'b0; sgn_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         cmp++;
         if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || get_p(d) !== 128'd0) begin
            errs++;
            $display("FAIL reset_state w=%0d: busy=%b done=%b p=%h, want 0 0 0",
                     wof(d), busy_v[d], done_v[d], get_p(d));
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed32();
      logic [63:0]  av[4]  = '{64'd3, 64'hFFFFFFF9, 64'h80000000, 64'hFFFFFFFF};
      logic [63:0]  bv[4]  = '{64'd5, 64'd6, 64'h80000000, 64'hFFFFFFFF};
      logic         sg[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [127:0] exp[4] = '{128'd15, 128'hFFFFFFFF_FFFFFFD6,
                               128'h40000000_00000000, 128'hFFFFFFFE_00000001};
      int           el[4]  = '{4, 5, 34, 34};
      logic [127:0] pv;
      int lat, bc;
      bit cl;
      for (int t = 0; t < 4; t++) begin
         run_op(3, sg[t], av[t], bv[t], pv, lat, bc, cl);
         cmp++;
         if (pv !== exp[t]) begin
            errs++;
            $display("FAIL dir32_p[%0d]: got %h want %h", t, pv, exp[t]);
         end
         cmp++;
         if (lat != el[t]) begin
            errs++;
            $display("FAIL dir32_latency[%0d]: got %0d want %0d", t, lat, el[t]);
         end
         cmp++;
         if (bc != el[t] || cl) begin
            errs++;
            $display("FAIL dir32_busy[%0d]: busy cycles %0d overlap %0d, want %0d and 0",
                     t, bc, cl, el[t]);
         end
      end
   endtask

   task automatic test_zero8();
      logic [63:0] av[2] = '{64'h00, 64'hFF};
      logic [63:0] bv[2] = '{64'hFF, 64'h00};
      logic [127:0] pv;
      int lat, bc;
      bit cl;
      for (int t = 0; t < 2; t++) begin
         run_op(1, 1'b1, av[t], bv[t], pv, lat, bc, cl);
         cmp++;
         if (pv !== 128'd0 || lat != 2 || bc != 2 || cl) begin
            errs++;
            $display("FAIL zero8[%0d]: p=%h lat=%0d busy=%0d, want p=0 lat=2 busy=2",
                     t, pv, lat, bc);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] first, pv;
      int lat, el;
      // Operation 1: 1234*567 unsigned; a second start mid-flight is ignored.
      sgn_v[2] = 1'b0; a_v[2] = 64'd1234; b_v[2] = 64'd567; start_v[2] = 1'b1;
      @(posedge clk); #1; start_v[2] = 1'b0;
      @(posedge clk); #1;
      sgn_v[2] = 1'b1; a_v[2] = 64'd9; b_v[2] = 64'd9; start_v[2] = 1'b1;
      @(posedge clk); #1; start_v[2] = 1'b0;
      lat = -1;
      for (int i = 2; i < 200; i++) begin
         if (done_v[2]) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      first = ref_mul(16, 1'b0, 64'd1234, 64'd567);
      el    = ref_lat(16, 1'b0, 64'd1234, 64'd567);
      cmp++;
      if (get_p(2) !== first || lat != el) begin
         errs++;
         $display("FAIL busy_ignore: p=%h lat=%0d, want p=%h lat=%0d", get_p(2), lat, first, el);
      end
      // Operation 2 issued in the done cycle; p must hold the first result.
      sgn_v[2] = 1'b1; a_v[2] = 64'hFED4; b_v[2] = 64'd77; start_v[2] = 1'b1;
      @(posedge clk); #1; start_v[2] = 1'b0;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (done_v[2]) begin
            lat = i;
            break;
         end
         cmp++;
         if (get_p(2) !== first) begin
            errs++;
            $display("FAIL b2b_hold: p=%h want %h", get_p(2), first);
         end
         @(posedge clk); #1;
      end
      pv = ref_mul(16, 1'b1, 64'hFED4, 64'd77);
      el = ref_lat(16, 1'b1, 64'hFED4, 64'd77);
      cmp++;
      if (get_p(2) !== pv || lat != el) begin
         errs++;
         $display("FAIL b2b_result: p=%h lat=%0d, want p=%h lat=%0d", get_p(2), lat, pv, el);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] pv;
      int lat, bc, nd;
      bit cl;
      sgn_v[3] = 1'b0; a_v[3] = 64'hFFFFFFFF; b_v[3] = 64'd3; start_v[3] = 1'b1;
      @(posedge clk); #1; start_v[3] = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      cmp++;
      if (busy_v[3] !== 1'b0 || done_v[3] !== 1'b0 || p32 !== 64'd0) begin
         errs++;
         $display("FAIL reset_mid: busy=%b done=%b p=%h, want 0 0 0", busy_v[3], done_v[3], p32);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_v[3] || busy_v[3]) nd++;
      end
      cmp++;
      if (nd != 0) begin
         errs++;
         $display("FAIL reset_no_done: %0d cycles with busy/done, want 0", nd);
      end
      run_op(3, 1'b1, 64'hFFFFFFFB, 64'd12345, pv, lat, bc, cl);
      cmp++;
      if (pv !== ref_mul(32, 1'b1, 64'hFFFFFFFB, 64'd12345) ||
          lat != ref_lat(32, 1'b1, 64'hFFFFFFFB, 64'd12345)) begin
         errs++;
         $display("FAIL after_reset: p=%h lat=%0d, want p=%h", pv, lat,
                  ref_mul(32, 1'b1, 64'hFFFFFFFB, 64'd12345));
      end
   endtask

   function automatic logic [63:0] pick(int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1 << (w - 1);
         2: return m;
         3: return 64'd1;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   task automatic test_random();
      int ds[3] = '{0, 1, 3};
      logic [127:0] pv, ep;
      logic [63:0] av, bv;
      logic sg;
      int lat, bc, el, w, shown;
      bit cl;
      shown = 0;
      for (int j = 0; j < 3; j++) begin
         w = wof(ds[j]);
         for (int n = 0; n < 1000; n++) begin
            av = pick(w); bv = pick(w); sg = 1'($urandom_range(0, 1));
            run_op(ds[j], sg, av, bv, pv, lat, bc, cl);
            ep = ref_mul(w, sg, av, bv);
            el = ref_lat(w, sg, av, bv);
            cmp++;
            if (pv !== ep || lat != el || bc != el || cl) begin
               errs++;
               if (shown < 20)
                  $display("FAIL rand w=%0d s=%0d a=%h b=%h: p=%h lat=%0d busy=%0d, want p=%h lat=%0d",
                           w, sg, av, bv, pv, lat, bc, ep, el);
               shown++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed32();
      test_zero8();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
